// File: rtl/adc_pattern_src.sv
// adc_pattern_src: multi-channel ADC test-pattern source on AXI-Stream.
// Define ADC_PATTERN_SRC_LFSR_EN to turn mode 3 into LFSR noise.
module adc_pattern_src #(
    parameter int          WIDTH     = 16,
    parameter int          NCHAN     = 1,
    parameter int          PERIOD    = 1,
    parameter int          FRAME_LEN = 64,
    parameter logic [31:0] SEED      = 32'h1,
    localparam int         UW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   amp,
    input  logic               clr_ovf,
    output logic [2*WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [UW-1:0]      m_axis_tuser,
    output logic               ovf,
    output logic [15:0]        drop_cnt
);

    typedef enum logic [1:0] { IDLE, RUN, EMIT } state_t;

    localparam logic [15:0]      PLAST = 16'(PERIOD - 1);
    localparam logic [WIDTH-1:0] FMASK = WIDTH'(FRAME_LEN - 1);
    localparam logic [UW-1:0]    CLAST = UW'(NCHAN - 1);

    if (WIDTH < 4 || WIDTH > 16 || NCHAN < 1 || NCHAN > 16 ||
        PERIOD < 1 || PERIOD > 65535 || SEED == 32'h0 ||
        FRAME_LEN < 1 || (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad
        $error("adc_pattern_src: illegal parameter set");
    end

    state_t             state;
    logic [15:0]        div_cnt;
    logic [WIDTH-1:0]   sidx;
    logic [WIDTH-1:0]   sidx_q;
    logic [WIDTH-1:0]   amp_q;
    logic [1:0]         mode_q;
    logic [UW-1:0]      ch;
    logic [UW-1:0]      nch;
    logic               tick;
    logic               hs;
    logic               last_hs;
    logic               start;
    logic               drop;
    logic [2*WIDTH-1:0] start_word;
    logic [2*WIDTH-1:0] next_word;
    logic               start_last;
    logic               next_last;

    assign tick    = en && (div_cnt == PLAST);
    assign hs      = m_axis_tvalid && m_axis_tready;
    assign last_hs = hs && (ch == CLAST);
    // a tick starts a burst unless one is still mid-flight
    assign start   = tick && ((state != EMIT) || last_hs);
    assign drop    = tick && !start;
    assign nch     = ch + UW'(1);

`ifdef ADC_PATTERN_SRC_LFSR_EN
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_nx;
    logic [2*WIDTH-1:0] noise;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    // the word being loaded sees the LFSR after this cycle's step
    assign lfsr_nx = hs ? lfsr_step(lfsr) : lfsr;
    assign noise   = {lfsr_nx[31:32-WIDTH], lfsr_nx[WIDTH-1:0]};

    // LFSR advances once per accepted channel word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_nx;
        end
    end
`endif

    function automatic logic [2*WIDTH-1:0] word(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] s,
        input logic [UW-1:0]    c
    );
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [WIDTH-1:0] v;
        v  = s + WIDTH'(c);
        re = '0;
        im = '0;
        case (m)
            2'd0: begin
                re = v;
                im = -v;
            end
            2'd1: re = ((s & FMASK) == '0) ? a : '0;
            2'd2: re = a;
            default: begin
`ifdef ADC_PATTERN_SRC_LFSR_EN
                {im, re} = noise;
`else
                re = a;
`endif
            end
        endcase
        return {im, re};
    endfunction

    // next output word, either for a fresh sample or the next channel
    always_comb begin
        start_word = word(mode, amp, sidx, '0);
        next_word  = word(mode_q, amp_q, sidx_q, nch);
        start_last = (CLAST == '0) && ((sidx & FMASK) == FMASK);
        next_last  = (nch == CLAST) && ((sidx_q & FMASK) == FMASK);
    end

    // tick divider and sample index; both freeze while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sidx    <= '0;
        end else if (en) begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (tick) begin
                sidx <= sidx + WIDTH'(1);
            end
        end
    end

    // burst sequencer with registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= '0;
            amp_q         <= '0;
            sidx_q        <= '0;
            ch            <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (start) begin
            state         <= EMIT;
            mode_q        <= mode;
            amp_q         <= amp;
            sidx_q        <= sidx;
            ch            <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= start_word;
            m_axis_tlast  <= start_last;
            m_axis_tuser  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                EMIT: begin
                    if (last_hs) begin
                        state         <= en ? RUN : IDLE;
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                    end else if (hs) begin
                        ch           <= nch;
                        m_axis_tdata <= next_word;
                        m_axis_tlast <= next_last;
                        m_axis_tuser <= nch;
                    end
                end
                default: ;
            endcase
        end
    end

    // overflow accounting; a drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_adc_pattern_src.sv
// tb_adc_pattern_src: four configurations of adc_pattern_src against a
// queue-based stream model, plus literal spot checks.
module tb_adc_pattern_src;

    localparam int N = 4;
    localparam int NC  [N] = '{1, 4, 2, 4};
    localparam int PER [N] = '{1, 4, 4, 2};
    localparam int FL  [N] = '{8, 4, 64, 4};
`ifdef ADC_PATTERN_SRC_LFSR_EN
    localparam bit LF = 1'b1;
    localparam logic [31:0] LW0 = 32'h0000_0001;
    localparam logic [31:0] LW1 = 32'h8020_0003;
`else
    localparam bit LF = 1'b0;
    localparam logic [31:0] LW0 = 32'h0000_1234;
    localparam logic [31:0] LW1 = 32'h0000_1234;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        clr   = 1'b0;
    logic        rdy   = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [15:0] amp   = 16'd0;

    logic [31:0] td [N];
    logic        tv [N];
    logic        tl [N];
    logic        ov [N];
    logic [15:0] dc [N];
    logic [3:0]  tu [N];
    logic [0:0]  tu0;
    logic [1:0]  tu1;
    logic [0:0]  tu2;
    logic [1:0]  tu3;

    assign tu[0] = 4'(tu0);
    assign tu[1] = 4'(tu1);
    assign tu[2] = 4'(tu2);
    assign tu[3] = 4'(tu3);

    always #5 clk = ~clk;

    adc_pattern_src #(.WIDTH(16), .NCHAN(1), .PERIOD(1), .FRAME_LEN(8), .SEED(32'h1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .amp(amp), .clr_ovf(clr),
        .m_axis_tdata(td[0]), .m_axis_tvalid(tv[0]), .m_axis_tready(rdy),
        .m_axis_tlast(tl[0]), .m_axis_tuser(tu0), .ovf(ov[0]), .drop_cnt(dc[0]));

    adc_pattern_src #(.WIDTH(16), .NCHAN(4), .PERIOD(4), .FRAME_LEN(4), .SEED(32'h1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .amp(amp), .clr_ovf(clr),
        .m_axis_tdata(td[1]), .m_axis_tvalid(tv[1]), .m_axis_tready(rdy),
        .m_axis_tlast(tl[1]), .m_axis_tuser(tu1), .ovf(ov[1]), .drop_cnt(dc[1]));

    adc_pattern_src #(.WIDTH(16), .NCHAN(2), .PERIOD(4), .FRAME_LEN(64), .SEED(32'h1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .amp(amp), .clr_ovf(clr),
        .m_axis_tdata(td[2]), .m_axis_tvalid(tv[2]), .m_axis_tready(rdy),
        .m_axis_tlast(tl[2]), .m_axis_tuser(tu2), .ovf(ov[2]), .drop_cnt(dc[2]));

    adc_pattern_src #(.WIDTH(16), .NCHAN(4), .PERIOD(2), .FRAME_LEN(4), .SEED(32'h1)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .amp(amp), .clr_ovf(clr),
        .m_axis_tdata(td[3]), .m_axis_tvalid(tv[3]), .m_axis_tready(rdy),
        .m_axis_tlast(tl[3]), .m_axis_tuser(tu3), .ovf(ov[3]), .drop_cnt(dc[3]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // model state: outstanding words per DUT, tick/sample counters, drops
    logic [37:0] q [N][$];
    int          encnt [N];
    int          nsmp  [N];
    int          mdrop [N];
    bit          mov   [N];
    logic [31:0] mlfsr [N];

    function automatic logic [31:0] mstep(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    // expected word {lfsr_flag, user, last, imag, real} for sample n channel c
    function automatic logic [37:0] mword(input int i, input int c, input logic [1:0] m,
                                          input logic [15:0] a, input int n);
        logic [15:0] v;
        logic [15:0] re;
        logic [15:0] im;
        bit          lf;
        bit          last;
        int          f;
        f  = n % FL[i];
        v  = 16'(n + c);
        re = 16'd0;
        im = 16'd0;
        lf = 1'b0;
        case (m)
            2'd0: begin re = v; im = 16'd0 - v; end
            2'd1: re = (f == 0) ? a : 16'd0;
            2'd2: re = a;
            default: if (LF) lf = 1'b1; else re = a;
        endcase
        last = (c == NC[i] - 1) && (f == FL[i] - 1);
        return {lf, 4'(c), last, im, re};
    endfunction

    // compare every DUT against the model, then advance the model one edge
    always @(negedge clk) begin : chkr
        logic [37:0] e;
        logic [31:0] ed;
        bit ev, hs, tk, dr;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                q[i].delete();
                encnt[i] = 0;
                nsmp[i]  = 0;
                mdrop[i] = 0;
                mov[i]   = 1'b0;
                mlfsr[i] = 32'h1;
                chk("rst_tvalid", i, 32'(tv[i]), 32'd0);
                chk("rst_tdata", i, td[i], 32'd0);
                chk("rst_tlast", i, 32'(tl[i]), 32'd0);
                chk("rst_tuser", i, 32'(tu[i]), 32'd0);
                chk("rst_ovf", i, 32'(ov[i]), 32'd0);
                chk("rst_drop", i, 32'(dc[i]), 32'd0);
            end else begin
                ev = (q[i].size() != 0);
                chk("tvalid", i, 32'(tv[i]), 32'(ev));
                if (ev) begin
                    e  = q[i][0];
                    ed = e[37] ? mlfsr[i] : e[31:0];
                    ed = e[37] ? {mlfsr[i][31:16], mlfsr[i][15:0]} : ed;
                    chk("tdata", i, td[i], ed);
                    chk("tlast", i, 32'(tl[i]), 32'(e[32]));
                    chk("tuser", i, 32'(tu[i]), 32'(e[36:33]));
                end
                chk("ovf", i, 32'(ov[i]), 32'(mov[i]));
                chk("drop_cnt", i, 32'(dc[i]), 32'(mdrop[i]));
                hs = ev && rdy;
                tk = en && ((encnt[i] % PER[i]) == PER[i] - 1);
                if (en) encnt[i]++;
                if (hs) begin
                    void'(q[i].pop_front());
                    mlfsr[i] = mstep(mlfsr[i]);
                end
                dr = 1'b0;
                if (tk) begin
                    if (q[i].size() == 0) begin
                        for (int c = 0; c < NC[i]; c++)
                            q[i].push_back(mword(i, c, mode, amp, nsmp[i]));
                    end else begin
                        dr = 1'b1;
                    end
                    nsmp[i]++;
                end
                if (dr) begin
                    mov[i]   = 1'b1;
                    mdrop[i] = clr ? 1 : ((mdrop[i] == 65535) ? mdrop[i] : mdrop[i] + 1);
                end else if (clr) begin
                    mov[i]   = 1'b0;
                    mdrop[i] = 0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        cyc(2);
        @(negedge clk);
        chk("lit_rst_tvalid", 0, 32'(tv[0]), 32'd0);
        chk("lit_rst_drop", 3, 32'(dc[3]), 32'd0);
        cyc(1);

        // ramp, full-rate ready
        rst_n = 1'b1; mode = 2'd0; rdy = 1'b1; en = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("lit_ramp0", 0, td[0], 32'h0000_0000);
        cyc(1);
        @(negedge clk);
        chk("lit_ramp1", 0, td[0], 32'hFFFF_0001);
        cyc(1);
        @(negedge clk);
        chk("lit_ramp2", 0, td[0], 32'hFFFE_0002);
        chk("lit_ramp2_last", 0, 32'(tl[0]), 32'd0);
        cyc(5);
        @(negedge clk);
        chk("lit_ramp7", 0, td[0], 32'hFFF9_0007);
        chk("lit_ramp7_last", 0, 32'(tl[0]), 32'd1);
        cyc(20);
        en = 1'b0;
        cyc(6);
        en = 1'b1;
        cyc(10);
        @(negedge clk);
        chk("lit_ovf_set", 3, 32'(ov[3]), 32'd1);
        chk("lit_ovf_clean", 1, 32'(ov[1]), 32'd0);
        chk("lit_ovf_clean", 0, 32'(ov[0]), 32'd0);
        cyc(1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(12);

        // impulse
        do_reset();
        mode = 2'd1; amp = 16'h4000; rdy = 1'b1; en = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("lit_imp_c0", 1, td[1], 32'h0000_4000);
        chk("lit_imp_u0", 1, 32'(tu[1]), 32'd0);
        cyc(3);
        @(negedge clk);
        chk("lit_imp_c3", 1, td[1], 32'h0000_4000);
        chk("lit_imp_u3", 1, 32'(tu[1]), 32'd3);
        cyc(1);
        @(negedge clk);
        chk("lit_imp_s1", 1, td[1], 32'h0000_0000);
        cyc(30);

        // DC under toggling backpressure
        do_reset();
        mode = 2'd2; amp = 16'h1234; en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rdy = (k % 2 == 0);
            cyc(1);
        end
        rdy = 1'b1;
        cyc(8);
        @(negedge clk);
        chk("lit_bp_drop", 2, 32'(dc[2]), 32'd0);
        chk("lit_bp_ovf", 2, 32'(ov[2]), 32'd0);
        cyc(1);

        // mode 3 noise
        do_reset();
        mode = 2'd3; amp = 16'h1234; rdy = 1'b1; en = 1'b1;
        cyc(1);
        @(negedge clk);
        chk("lit_lfsr0", 0, td[0], LW0);
        cyc(1);
        @(negedge clk);
        chk("lit_lfsr1", 0, td[0], LW1);
        cyc(20);

        // reset mid-burst
        do_reset();
        mode = 2'd0; rdy = 1'b1; en = 1'b1;
        cyc(6);
        @(negedge clk);
        chk("lit_mid_user", 1, 32'(tu[1]), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("lit_mid_tvalid", 1, 32'(tv[1]), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("lit_restart0", 1, td[1], 32'h0000_0000);
        cyc(1);
        @(negedge clk);
        chk("lit_restart1", 1, td[1], 32'hFFFF_0001);
        chk("lit_restart_u", 1, 32'(tu[1]), 32'd1);
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
